riscv_multicycle_ctrl: RTL
==========================

RISCV_MULTICYCLE_CTRL -- requirements
Module: riscv_multicycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, the maximum number of cycles to wait for mem_ready before the error state.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port op, input, 7, instruction register bits [6:0].
REQ-005 SHALL have ports funct3 (input, 3) and funct7b5 (input, 1), instruction register bits [14:12] and [30].
REQ-006 SHALL have port mem_ready, input, 1, memory completes the current request this cycle.
REQ-007 SHALL have outputs mem_req, mem_we, addr_src (0=PC, 1=ALU_OUT), each 1 bit.
REQ-008 SHALL have outputs ir_write, pc_write, reg_write, each 1 bit.
REQ-009 SHALL have output imm_sel, 2 bits, immediate format select for the extender: I=0, S=1, J=2.
REQ-010 SHALL have outputs alu_src_a (2: PC=0, OLD_PC=1, RS1=2) and alu_src_b (2: RS2=0, IMM=1, FOUR=2).
REQ-011 SHALL have outputs alu_ctrl (3: ADD=000, SUB=001, AND=010, OR=011, SLT=100) and result_src (2: ALU_OUT=0, MEM_DATA=1, ALU_RESULT=2).
REQ-012 SHALL have outputs illegal, 1 bit, and timeout, 1 bit; both are sticky error flags.

Function
REQ-013 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, EXEC_I, ALUWB, JAL, ERROR.
REQ-014 SHALL default every output to 0 in every state, except where a state below drives it.
REQ-015 FETCH: mem_req=1, addr_src=PC, a=PC, b=FOUR, ADD, result_src=ALU_RESULT; on mem_ready, ir_write=1, pc_write=1 and the next state is DECODE; otherwise the FSM holds.
REQ-016 DECODE: a=OLD_PC, b=IMM, imm_sel=J, ADD; next state by op: 0000011/0100011 to MEMADR, 0110011 to EXEC_R, 0010011 to EXEC_I, 1101111 to JAL, any other op to ERROR.
REQ-017 MEMADR: a=RS1, b=IMM, ADD, imm_sel=I for a load or S for a store; next state is MEMRD for a load or MEMWR for a store.
REQ-018 MEMRD: mem_req=1, addr_src=ALU_OUT; on mem_ready the next state is MEMWB. MEMWB: result_src=MEM_DATA, reg_write=1; next state is FETCH.
REQ-019 MEMWR: mem_req=1, mem_we=1, addr_src=ALU_OUT; on mem_ready the next state is FETCH.
REQ-020 EXEC_R: a=RS1, b=RS2, decoded alu_ctrl; next state is ALUWB. EXEC_I: a=RS1, b=IMM, imm_sel=I, decoded alu_ctrl; next state is ALUWB.
REQ-021 SHALL decode funct3 as: 000 gives SUB if R-type and funct7b5=1, else ADD; 010 gives SLT; 110 gives OR; 111 gives AND. Any other funct3 in EXEC_R/EXEC_I SHALL go to ERROR instead of ALUWB.
REQ-022 ALUWB: result_src=ALU_OUT, reg_write=1; next state is FETCH.
REQ-023 JAL: a=OLD_PC, b=FOUR, ADD, result_src=ALU_OUT, pc_write=1; next state is ALUWB, which writes rd=PC+4.
REQ-024 Instruction latency without wait states: load 5 cycles, store 4, R/I-type 4, JAL 4.
REQ-025 SHALL keep a wait counter that clears on entry to FETCH, MEMRD or MEMWR and increments each cycle that mem_req=1 and mem_ready=0.
REQ-026 SHALL set timeout and enter ERROR, with no enable asserted that cycle, when the wait counter equals MEM_TIMEOUT while mem_ready=0.
REQ-027 SHALL give mem_ready priority over timeout when both occur in the same cycle.
REQ-028 ERROR: all enables 0; the FSM holds until reset; illegal is set on entry from an illegal decode.
REQ-029 SHALL ignore mem_ready in every state without mem_req.

Reset
REQ-030 rst_n low SHALL immediately force the FSM to FETCH, clear the wait counter, and clear illegal and timeout, regardless of the current state or a pending request.
REQ-031 While rst_n is low, SHALL hold ir_write, pc_write, reg_write and mem_we at 0; mem_req=1 is allowed only after reset release.

Structure
REQ-032 SHALL place the state enum, the imm_sel/alu_ctrl/src encodings and the opcode constants in shared package riscv_pkg.
REQ-033 SHALL implement the funct3/funct7b5 decode as combinational sub-module riscv_alu_decoder.

Verification
REQ-034 ADDI x1,x0,5 (0x00500093), mem_ready high immediately -> FETCH, DECODE, EXEC_I, ALUWB; imm_sel=0, alu_ctrl=000 in EXEC_I; reg_write for exactly 1 cycle.
REQ-035 LW (op 0000011), mem_ready delayed 3 cycles in MEMRD -> FSM holds MEMRD with mem_req=1 and addr_src=1 for 4 cycles, then 1 cycle of MEMWB with result_src=1.
REQ-036 SW (op 0100011) -> imm_sel=1 in MEMADR; mem_we=1 only in MEMWR; reg_write never asserted.
REQ-037 JAL (op 1101111) -> imm_sel=2 in DECODE; pc_write in FETCH and JAL; rd is written in ALUWB.
REQ-038 Illegal op 1111111, or R-type funct3=001 -> ERROR with illegal=1; with MEM_TIMEOUT=4 and mem_ready low in FETCH -> timeout=1 after 4 wait cycles; async rst_n mid-MEMWR -> FETCH and flags cleared.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared state, encoding and opcode definitions for the multicycle controller
package riscv_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC_R,
        S_EXEC_I,
        S_ALUWB,
        S_JAL,
        S_ERROR
    } state_t;

    localparam logic [1:0] IMM_I = 2'd0;
    localparam logic [1:0] IMM_S = 2'd1;
    localparam logic [1:0] IMM_J = 2'd2;

    localparam logic       ADDR_PC      = 1'b0;
    localparam logic       ADDR_ALU_OUT = 1'b1;

    localparam logic [1:0] SRCA_PC     = 2'd0;
    localparam logic [1:0] SRCA_OLD_PC = 2'd1;
    localparam logic [1:0] SRCA_RS1    = 2'd2;

    localparam logic [1:0] SRCB_RS2  = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [1:0] RES_ALU_OUT    = 2'd0;
    localparam logic [1:0] RES_MEM_DATA   = 2'd1;
    localparam logic [1:0] RES_ALU_RESULT = 2'd2;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

endpackage

// File: rtl/riscv_alu_decoder.sv
// rtl/riscv_alu_decoder.sv - combinational funct3/funct7b5 to alu_ctrl decode with legality flag
module riscv_alu_decoder
    import riscv_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       is_rtype,
    output logic [2:0] alu_ctrl,
    output logic       legal
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        legal    = 1'b1;
        case (funct3)
            3'b000:  alu_ctrl = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_ctrl = ALU_SLT;
            3'b110:  alu_ctrl = ALU_OR;
            3'b111:  alu_ctrl = ALU_AND;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// rtl/riscv_multicycle_ctrl.sv - multicycle RISC-V control FSM with memory wait timeout and sticky error flags
module riscv_multicycle_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] imm_sel,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_ctrl,
    output logic [1:0] result_src,
    output logic       illegal,
    output logic       timeout
);

    localparam int unsigned    CNT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             illegal_q, illegal_d;
    logic             timeout_q, timeout_d;

    logic mem_req_c, mem_we_c, ir_write_c, pc_write_c, reg_write_c;
    logic ill_entry, to_entry;
    logic [2:0] dec_alu_ctrl;
    logic       dec_legal;

    riscv_alu_decoder u_alu_decoder (
        .funct3   (funct3),
        .funct7b5 (funct7b5),
        .is_rtype (op == OP_RTYPE),
        .alu_ctrl (dec_alu_ctrl),
        .legal    (dec_legal)
    );

    always_comb begin
        state_d     = state_q;
        mem_req_c   = 1'b0;
        mem_we_c    = 1'b0;
        ir_write_c  = 1'b0;
        pc_write_c  = 1'b0;
        reg_write_c = 1'b0;
        addr_src    = ADDR_PC;
        imm_sel     = IMM_I;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_RS2;
        alu_ctrl    = ALU_ADD;
        result_src  = RES_ALU_OUT;
        ill_entry   = 1'b0;
        to_entry    = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req_c  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU_RESULT;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLD_PC;
                alu_src_b = SRCB_IMM;
                imm_sel   = IMM_J;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXEC_R;
                    OP_ITYPE:          state_d = S_EXEC_I;
                    OP_JAL:            state_d = S_JAL;
                    default: begin
                        state_d   = S_ERROR;
                        ill_entry = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                imm_sel   = (op == OP_STORE) ? IMM_S : IMM_I;
                state_d   = (op == OP_STORE) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req_c = 1'b1;
                addr_src  = ADDR_ALU_OUT;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src  = RES_MEM_DATA;
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWR: begin
                mem_req_c = 1'b1;
                mem_we_c  = 1'b1;
                addr_src  = ADDR_ALU_OUT;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXEC_R, S_EXEC_I: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = (state_q == S_EXEC_I) ? SRCB_IMM : SRCB_RS2;
                alu_ctrl  = dec_alu_ctrl;
                state_d   = dec_legal ? S_ALUWB : S_ERROR;
                ill_entry = !dec_legal;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_JAL: begin
                alu_src_a  = SRCA_OLD_PC;
                alu_src_b  = SRCB_FOUR;
                pc_write_c = 1'b1;
                state_d    = S_ALUWB;
            end
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_ERROR;
        endcase

        // A completing access always wins; only a still-stalled request at the limit times out.
        if (mem_req_c && !mem_ready && wait_cnt_q == CNT_MAX) begin
            state_d  = S_ERROR;
            to_entry = 1'b1;
            mem_we_c = 1'b0;
        end

        wait_cnt_d = wait_cnt_q;
        if (state_d != state_q && (state_d inside {S_FETCH, S_MEMRD, S_MEMWR})) begin
            wait_cnt_d = '0;
        end else if (mem_req_c && !mem_ready && wait_cnt_q != CNT_MAX) begin
            wait_cnt_d = wait_cnt_q + CNT_ONE;
        end

        illegal_d = illegal_q | ill_entry;
        timeout_d = timeout_q | to_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
            illegal_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            illegal_q  <= illegal_d;
            timeout_q  <= timeout_d;
        end
    end

    // Enables are gated by rst_n so nothing fires while reset is held in FETCH.
    assign mem_req   = mem_req_c & rst_n;
    assign mem_we    = mem_we_c & rst_n;
    assign ir_write  = ir_write_c & rst_n;
    assign pc_write  = pc_write_c & rst_n;
    assign reg_write = reg_write_c & rst_n;
    assign illegal   = illegal_q;
    assign timeout   = timeout_q;

endmodule
